// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit log shifter (SLL/SRL/SRA/ROR) between two
// requesters, with a single-entry registered response buffer tagged by requester ID.
module shift_unit_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_data_i,
    input  logic [4:0]  req0_shamt_i,
    input  logic [1:0]  req0_op_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_data_i,
    input  logic [4:0]  req1_shamt_i,
    input  logic [1:0]  req1_op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_id_o
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;
    logic        last_grant_q, last_grant_d;

    logic        can_accept;
    logic        grant_any;
    logic        grant_sel;
    logic        accept;
    logic [31:0] sh_data;
    logic [4:0]  sh_amt;
    shift_op_e   sh_op;
    logic [31:0] sh_res;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        can_accept   = !rsp_valid_q || rsp_ready_i;
        grant_any    = req0_valid_i || req1_valid_i;
        grant_sel    = (req0_valid_i && req1_valid_i) ? !last_grant_q : req1_valid_i;
        req0_ready_o = !rst_i && can_accept && grant_any && !grant_sel;
        req1_ready_o = !rst_i && can_accept && grant_any && grant_sel;
        accept       = req0_ready_o || req1_ready_o;
    end

    always_comb begin
        sh_data = grant_sel ? req1_data_i  : req0_data_i;
        sh_amt  = grant_sel ? req1_shamt_i : req0_shamt_i;
        sh_op   = shift_op_e'(grant_sel ? req1_op_i : req0_op_i);
    end

    // Five conditional stages of 1/2/4/8/16 bits, one per shift-amount bit.
    always_comb begin
        sh_res = sh_data;
        for (int k = 0; k < 5; k++) begin
            if (sh_amt[k]) begin
                case (sh_op)
                    OP_SLL:  sh_res = sh_res << (1 << k);
                    OP_SRL:  sh_res = sh_res >> (1 << k);
                    OP_SRA:  sh_res = $signed(sh_res) >>> (1 << k);
                    default: sh_res = (sh_res >> (1 << k)) | (sh_res << (32 - (1 << k)));
                endcase
            end
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = sh_res;
            rsp_id_d     = grant_sel;
            last_grant_d = grant_sel;
        end else if (rsp_ready_i) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'h0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;

endmodule
